// File: rtl/cga_scandoubler.sv
// CGA 15.7 kHz to 31.5 kHz line doubler: ping-pong line buffer, each captured line replayed twice.
// Optional CGA_SCANLINES_EN: the second replay of each line is dimmed.
module cga_scandoubler #(
  parameter int LINE_MAX = 1024,
  parameter int CNT_W    = 12,
  parameter int HS_WIDTH = 54,
  parameter int DE_START = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_ce_in,
  input  logic [3:0] video_in,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [3:0] video,
  output logic       display_enable,
  output logic       hsync,
  output logic       vsync
);

  localparam int DATA_W = 4;
  localparam int AW     = $clog2(LINE_MAX);
  localparam int DEPTH  = 2 ** AW;
  localparam int LW     = AW + 1;
  localparam int EW     = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef CGA_SCANLINES_EN
  // Clearing I leaves every pixel low-intensity, and low-intensity pixels blank,
  // so the dimmed pass comes out black.
  function automatic logic [DATA_W-1:0] dim_pixel(input logic [DATA_W-1:0] pix);
    logic [DATA_W-1:0] dim;
    dim = pix & {1'b0, {(DATA_W-1){1'b1}}};
    return dim[DATA_W-1] ? dim : '0;
  endfunction
`endif

  logic [DATA_W-1:0] mem [2*DEPTH];

  logic              hs_prev;
  logic              hs_rise;
  logic              seen_rise;
  logic              wsel;
  logic              we;
  logic [LW-1:0]     wr_addr;
  logic [LW-1:0]     line_len;
  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  h_total;
  logic [CNT_W-1:0]  h_half;
  logic [CNT_W-1:0]  out_cnt;
  state_t            state_q;
  state_t            state_d;
  logic              pass_start;
  logic              vs_line;

  assign hs_rise = pixel_ce_in & hsync_in & ~hs_prev;
  assign we      = pixel_ce_in & de_in & ~hs_rise & (wr_addr < LW'(LINE_MAX));
  assign h_half  = h_total >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev   <= 1'b0;
      seen_rise <= 1'b0;
      wsel      <= 1'b0;
      wr_addr   <= '0;
      line_len  <= '0;
      h_cnt     <= '0;
      h_total   <= '0;
      out_cnt   <= '0;
      vs_line   <= 1'b0;
      state_q   <= IDLE;
    end else begin
      state_q <= state_d;
      if (pixel_ce_in) hs_prev <= hsync_in;
      if (hs_rise) begin
        seen_rise <= 1'b1;
        wsel      <= ~wsel;
        wr_addr   <= '0;
        line_len  <= wr_addr;
        h_total   <= sat_inc(h_cnt);
        h_cnt     <= '0;
      end else begin
        h_cnt <= sat_inc(h_cnt);
        if (we) wr_addr <= wr_addr + LW'(1);
      end
      out_cnt <= pass_start ? '0 : sat_inc(out_cnt);
      if (pass_start) vs_line <= vsync_in;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wsel, wr_addr[AW-1:0]}] <= video_in;
  end

  // A rise always restarts PASS0, which truncates the line if PASS1 has not begun.
  always_comb begin
    state_d    = state_q;
    pass_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs_rise && seen_rise) begin
          state_d    = PASS0;
          pass_start = 1'b1;
        end
      end
      PASS0: begin
        if (hs_rise) begin
          pass_start = 1'b1;
        end else if (out_cnt == h_half - CNT_W'(1)) begin
          state_d    = PASS1;
          pass_start = 1'b1;
        end
      end
      PASS1: begin
        if (hs_rise) begin
          state_d    = PASS0;
          pass_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: timing decode from out_cnt
  logic [EW-1:0] out_ext;
  logic [EW-1:0] de_end;
  logic [AW-1:0] rd_addr;
  logic          active;
  logic          vld_p0;
  logic          hs_p0;

  assign active  = (state_q != IDLE);
  assign out_ext = {1'b0, out_cnt};
  assign de_end  = EW'(DE_START) + EW'(line_len);
  assign vld_p0  = active && (out_ext >= EW'(DE_START)) && (out_ext < de_end);
  assign hs_p0   = active && (out_cnt < CNT_W'(HS_WIDTH));
  assign rd_addr = AW'(out_cnt - CNT_W'(DE_START));

  // Stage p1: registered buffer read, controls delayed alongside
  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;
  logic              hs_p1;
  logic              vs_p1;

  always_ff @(posedge clk) begin
    rdata_p1 <= mem[{~wsel, rd_addr}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_line;
    end
  end

`ifdef CGA_SCANLINES_EN
  logic pass1_p1;
  always_ff @(posedge clk) begin
    if (reset) pass1_p1 <= 1'b0;
    else       pass1_p1 <= (state_q == PASS1);
  end
`endif

  // Stage p2: output registers, video blanked outside display enable
  always_ff @(posedge clk) begin
    if (reset) begin
      video          <= '0;
      display_enable <= 1'b0;
      hsync          <= 1'b0;
      vsync          <= 1'b0;
    end else begin
`ifdef CGA_SCANLINES_EN
      video <= !vld_p1 ? '0 : (pass1_p1 ? dim_pixel(rdata_p1) : rdata_p1);
`else
      video <= vld_p1 ? rdata_p1 : '0;
`endif
      display_enable <= vld_p1;
      hsync          <= hs_p1;
      vsync          <= vs_p1;
    end
  end

endmodule

// File: tb/tb_cga_scandoubler.sv
// Scoreboard bench for cga_scandoubler: line sender pushes expected pixels/DE runs, monitor checks them.
module tb_cga_scandoubler;
  localparam int LINE_MAX = 1024;
  localparam int CNT_W    = 12;
  localparam int HS_WIDTH = 54;
  localparam int DE_START = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_ce_in;
  logic [3:0] video_in;
  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [3:0] video;
  logic       display_enable;
  logic       hsync;
  logic       vsync;

  cga_scandoubler #(
    .LINE_MAX(LINE_MAX), .CNT_W(CNT_W), .HS_WIDTH(HS_WIDTH), .DE_START(DE_START)
  ) dut (
    .clk(clk), .reset(reset), .pixel_ce_in(pixel_ce_in), .video_in(video_in),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in), .video(video),
    .display_enable(display_enable), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int start; int len; } run_t;

  logic [3:0] pix_q[$];
  run_t       run_q[$];
  logic [3:0] pend_pix[$];
  int         pend_period = 0;
  bit         have_pend = 0;
  bit         vs_model = 0;
  bit         skip_mon = 1;
  bit         de_seen = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] pass1_exp(input logic [3:0] p);
`ifdef CGA_SCANLINES_EN
    return 4'h0;
`else
    return p;
`endif
  endfunction

  // Queue the two replays of the previously sent line, given the rise cycle that ends it.
  task automatic flush_pending(input int r, input int next_p);
    int half;
    int n;
    if (!have_pend) return;
    half = pend_period / 2;
    n = pend_pix.size();
    if (n == 0) return;
    foreach (pend_pix[i]) pix_q.push_back(pend_pix[i]);
    run_q.push_back('{start: r + 2 + DE_START, len: n});
    if (next_p >= half + DE_START + n) begin
      foreach (pend_pix[i]) pix_q.push_back(pass1_exp(pend_pix[i]));
      run_q.push_back('{start: r + 2 + DE_START + half, len: n});
    end
  endtask

  task automatic do_reset_midline();
    reset = 1'b1;
    skip_mon = 1;
    hsync_in = 1'b0;
    de_in = 1'b0;
    pixel_ce_in = 1'b0;
    @(negedge clk);
    check("rst_mid_video", video, 0);
    check("rst_mid_de", display_enable, 0);
    check("rst_mid_hsync", hsync, 0);
    check("rst_mid_vsync", vsync, 0);
    reset = 1'b0;
    pix_q.delete();
    run_q.delete();
    have_pend = 0;
    vs_model = 0;
    repeat (3) @(negedge clk);
    skip_mon = 0;
  endtask

  // mode 0: ramp (base+i) mod 16; mode 1: alternating 1100 / 0101
  task automatic send_line(input int npix, input int period, input int mode, input int base,
                           input bit vs, input int abort_px);
    int r;
    bit disp;
    bit prev_vs;
    int idx;
    logic [3:0] p;
    logic [3:0] cur[$];
    r = 0;
    disp = 0;
    prev_vs = 0;
    for (int c = 0; c < period; c++) begin
      @(negedge clk);
      de_seen = de_seen | display_enable;
      if (c == 0) begin
        r = cyc + 1;
        flush_pending(r, period);
        disp = have_pend;
        prev_vs = vs_model;
        if (disp) vs_model = vs;
        have_pend = 0;
      end
      if (c == 2) check("vsync_before", vsync, prev_vs);
      if (c == 3) begin
        check("hsync_start", hsync, disp);
        check("vsync_after", vsync, vs_model);
      end
      if (c == HS_WIDTH + 2) check("hsync_last", hsync, disp);
      if (c == HS_WIDTH + 3) check("hsync_end", hsync, 0);
      if (abort_px >= 0 && c == 100 + 2 * abort_px) begin
        do_reset_midline();
        return;
      end
      pixel_ce_in = (c % 2 == 0);
      hsync_in = (c < 32);
      vsync_in = vs;
      de_in = (c >= 100) && (c < 100 + 2 * npix);
      idx = (c - 100) / 2;
      if (mode == 1) p = idx[0] ? 4'b0101 : 4'b1100;
      else p = 4'((base + idx) % 16);
      video_in = de_in ? p : 4'h0;
      if (de_in && pixel_ce_in && cur.size() < LINE_MAX) cur.push_back(p);
    end
    pend_pix = cur;
    pend_period = period;
    have_pend = 1;
  endtask

  // Monitor: pops one expected pixel per DE cycle and one run record per DE run.
  int run_start = 0;
  int run_len = 0;
  bit in_run = 0;
  always @(negedge clk) begin
    logic [3:0] exp_pix;
    run_t r;
    if (skip_mon) begin
      in_run = 0;
    end else if (display_enable) begin
      if (!in_run) begin
        in_run = 1;
        run_start = cyc;
        run_len = 0;
      end
      run_len++;
      if (pix_q.size() == 0) check("unexpected_pixel", 1, 0);
      else begin
        exp_pix = pix_q.pop_front();
        check("pixel", video, exp_pix);
      end
    end else begin
      check("blank_video", video, 0);
      if (in_run) begin
        in_run = 0;
        if (run_q.size() == 0) check("unexpected_de_run", 1, 0);
        else begin
          r = run_q.pop_front();
          check("de_start", run_start, r.start);
          check("de_len", run_len, r.len);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    pixel_ce_in = 1'b0;
    video_in = 4'h0;
    de_in = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_video", video, 0);
    check("reset_de", display_enable, 0);
    check("reset_hsync", hsync, 0);
    check("reset_vsync", vsync, 0);
    reset = 1'b0;
    skip_mon = 0;

    // basic doubling
    send_line(640, 1824, 0, 0, 0, -1);
    send_line(640, 1824, 0, 5, 0, -1);
    send_line(640, 1824, 0, 9, 0, -1);
    // overflow, then a spacer line long enough for its second pass
    send_line(1100, 2400, 0, 3, 0, -1);
    send_line(300, 2400, 0, 6, 0, -1);
    // odd period
    send_line(640, 1825, 0, 7, 0, -1);
    // short line skips PASS1 of the line before it
    send_line(200, 1824, 0, 2, 0, -1);
    send_line(200, 600, 0, 11, 0, -1);
    // vsync alignment
    send_line(100, 1824, 0, 4, 1, -1);
    send_line(100, 1824, 0, 6, 0, -1);
    // scanline pattern
    send_line(64, 1824, 1, 0, 0, -1);
    send_line(640, 1824, 0, 1, 0, -1);
    // reset mid-line, then two rises needed before output
    send_line(640, 1824, 0, 0, 0, 300);
    de_seen = 0;
    send_line(100, 1824, 0, 8, 0, -1);
    check("no_de_before_2nd_rise", de_seen, 0);
    send_line(100, 1824, 0, 12, 0, -1);
    send_line(0, 1824, 0, 0, 0, -1);
    send_line(0, 200, 0, 0, 0, -1);
    repeat (100) @(negedge clk);
    check("pix_q_drained", pix_q.size(), 0);
    check("run_q_drained", run_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
